// File: rtl/tff_bank_pkg.sv
// Shared definitions for the T flip-flop bank: mode encodings.
package tff_bank_pkg;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DN     = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/tff_ovr_ctrl.sv
// Per-bit hardware override: holds the force mask/value and muxes them over
// the architectural state to form the effective output.
module tff_ovr_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ovr_set_i,
    input  logic [WIDTH-1:0] ovr_mask_i,
    input  logic [WIDTH-1:0] ovr_data_i,
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] sel_o
);

    logic [WIDTH-1:0] ovr_en_q, ovr_en_d;
    logic [WIDTH-1:0] ovr_val_q, ovr_val_d;

    always_comb begin
        ovr_en_d  = ovr_en_q;
        ovr_val_d = ovr_val_q;
        if (ovr_set_i) begin
            ovr_en_d  = ovr_mask_i;
            ovr_val_d = ovr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovr_en_q  <= '0;
            ovr_val_q <= '0;
        end else begin
            ovr_en_q  <= ovr_en_d;
            ovr_val_q <= ovr_val_d;
        end
    end

    assign q_o   = (state_i & ~ovr_en_q) | (ovr_val_q & ovr_en_q);
    assign sel_o = ovr_en_q;

endmodule

// File: rtl/tff_bank.sv
// Bank of T flip-flops with parallel load, per-bit override and an optional
// chained up/down counter mode with terminal-count pulse.
module tff_bank
    import tff_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned STICKY   = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] t_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             ovr_set_i,
    input  logic [WIDTH-1:0] ovr_mask_i,
    input  logic [WIDTH-1:0] ovr_data_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_bar_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] Ones = '1;
    localparam logic [WIDTH-1:0] Zero = '0;
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);
    localparam bit Sat = (SATURATE != 0);
    localparam bit Stk = (STICKY != 0);

    logic [WIDTH-1:0] state_q, state_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] q_eff, ovr_sel;
    logic [WIDTH-1:0] opnd, nxt;

    tff_ovr_ctrl #(
        .WIDTH (WIDTH)
    ) u_ovr_ctrl (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ovr_set_i  (ovr_set_i),
        .ovr_mask_i (ovr_mask_i),
        .ovr_data_i (ovr_data_i),
        .state_i    (state_q),
        .q_o        (q_eff),
        .sel_o      (ovr_sel)
    );

    // Non-sticky overrides leave the internal state evolving on its own value.
    assign opnd = Stk ? q_eff : state_q;

    always_comb begin
        nxt  = opnd;
        tc_d = 1'b0;
        case (mode_i)
            MODE_TOGGLE: nxt = opnd ^ t_i;
            MODE_UP: begin
                if (t_i[0]) begin
                    if (opnd == Ones) begin
                        nxt  = Sat ? Ones : Zero;
                        tc_d = !Sat;
                    end else begin
                        nxt  = opnd + One;
                        tc_d = Sat && (opnd == Ones - One);
                    end
                end
            end
            MODE_DN: begin
                if (t_i[0]) begin
                    if (opnd == Zero) begin
                        nxt  = Sat ? Zero : Ones;
                        tc_d = !Sat;
                    end else begin
                        nxt  = opnd - One;
                        tc_d = Sat && (opnd == One);
                    end
                end
            end
            default: nxt = opnd;
        endcase
        if (Stk) begin
            nxt = (nxt & ~ovr_sel) | (q_eff & ovr_sel);
        end
        state_d = nxt;
        if (load_i) begin
            state_d = load_val_i;
            tc_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign q_o     = q_eff;
    assign q_bar_o = ~q_eff;
    assign tc_o    = tc_q;

endmodule

// File: tb/tb_tff_bank.sv
// Directed bench for tff_bank: three WIDTH=4 variants share one stimulus.
module tb_tff_bank;

    localparam logic [1:0] MT = 2'b00;
    localparam logic [1:0] MU = 2'b01;
    localparam logic [1:0] MD = 2'b10;
    localparam logic [1:0] MH = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = MH;
    logic [3:0] t = '0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       ovr_set = 1'b0;
    logic [3:0] ovr_mask = '0;
    logic [3:0] ovr_data = '0;

    // a: wrap + sticky, b: saturate + sticky, c: wrap + non-sticky
    logic [3:0] qa, qba, qb, qbb, qc, qbc;
    logic       tca, tcb, tcc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tff_bank #(.WIDTH(4), .SATURATE(0), .STICKY(1)) u_a (
        .clk_i(clk), .reset_i(reset), .mode_i(mode), .t_i(t), .load_i(load),
        .load_val_i(load_val), .ovr_set_i(ovr_set), .ovr_mask_i(ovr_mask),
        .ovr_data_i(ovr_data), .q_o(qa), .q_bar_o(qba), .tc_o(tca)
    );
    tff_bank #(.WIDTH(4), .SATURATE(1), .STICKY(1)) u_b (
        .clk_i(clk), .reset_i(reset), .mode_i(mode), .t_i(t), .load_i(load),
        .load_val_i(load_val), .ovr_set_i(ovr_set), .ovr_mask_i(ovr_mask),
        .ovr_data_i(ovr_data), .q_o(qb), .q_bar_o(qbb), .tc_o(tcb)
    );
    tff_bank #(.WIDTH(4), .SATURATE(0), .STICKY(0)) u_c (
        .clk_i(clk), .reset_i(reset), .mode_i(mode), .t_i(t), .load_i(load),
        .load_val_i(load_val), .ovr_set_i(ovr_set), .ovr_mask_i(ovr_mask),
        .ovr_data_i(ovr_data), .q_o(qc), .q_bar_o(qbc), .tc_o(tcc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_qa", 32'(qa), 32'h0);
        chk("rst_qbara", 32'(qba), 32'hF);
        chk("rst_tca", 32'(tca), 32'h0);
        chk("rst_qc", 32'(qc), 32'h0);
        reset = 1'b0;

        // TOGGLE t=0101
        mode = MT;
        t = 4'b0101;
        tick(); chk("tog1_q", 32'(qa), 32'h5); chk("tog1_qbar", 32'(qba), 32'hA);
        tick(); chk("tog2_q", 32'(qa), 32'h0); chk("tog2_qbar", 32'(qba), 32'hF);
        tick(); chk("tog3_q", 32'(qa), 32'h5); chk("tog3_tc", 32'(tca), 32'h0);

        // Wrapping up/down count from E
        load = 1'b1; load_val = 4'hE; mode = MU; t = 4'b0001;
        tick(); chk("ld_q", 32'(qa), 32'hE);
        load = 1'b0;
        tick(); chk("up1_q", 32'(qa), 32'hF); chk("up1_tc", 32'(tca), 32'h0);
        tick(); chk("up2_q", 32'(qa), 32'h0); chk("up2_tc", 32'(tca), 32'h1);
        tick(); chk("up3_q", 32'(qa), 32'h1); chk("up3_tc", 32'(tca), 32'h0);
        mode = MD;
        tick(); chk("dn1_q", 32'(qa), 32'h0); chk("dn1_tc", 32'(tca), 32'h0);
        tick(); chk("dn2_q", 32'(qa), 32'hF); chk("dn2_tc", 32'(tca), 32'h1);
        t = 4'b1110;
        tick(); chk("dn_noen_q", 32'(qa), 32'hF); chk("dn_noen_tc", 32'(tca), 32'h0);

        // Saturating up count from D
        load = 1'b1; load_val = 4'hD; mode = MU; t = 4'b0001;
        tick(); chk("sld_q", 32'(qb), 32'hD);
        load = 1'b0;
        tick(); chk("sup1_q", 32'(qb), 32'hE); chk("sup1_tc", 32'(tcb), 32'h0);
        tick(); chk("sup2_q", 32'(qb), 32'hF); chk("sup2_tc", 32'(tcb), 32'h1);
        tick(); chk("sup3_q", 32'(qb), 32'hF); chk("sup3_tc", 32'(tcb), 32'h0);
        tick(); chk("sup4_q", 32'(qb), 32'hF); chk("sup4_tc", 32'(tcb), 32'h0);

        // Override on bit 0 while toggling: sticky (a) vs non-sticky (c)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mode = MT; t = 4'b0001;
        ovr_set = 1'b1; ovr_mask = 4'b0001; ovr_data = 4'b0001;
        tick(); chk("ov1_qa", 32'(qa), 32'h1); chk("ov1_qc", 32'(qc), 32'h1);
        ovr_set = 1'b0;
        tick(); chk("ov2_qa", 32'(qa), 32'h1); chk("ov2_qc", 32'(qc), 32'h1);
        tick(); chk("ov3_qa", 32'(qa), 32'h1); chk("ov3_qc", 32'(qc), 32'h1);
        ovr_set = 1'b1; ovr_mask = 4'b0000; ovr_data = 4'b0000;
        tick(); chk("rel1_qa", 32'(qa), 32'h1); chk("rel1_qc", 32'(qc), 32'h0);
        chk("rel1_qbarc", 32'(qbc), 32'hF);
        ovr_set = 1'b0;
        tick(); chk("rel2_qa", 32'(qa), 32'h0); chk("rel2_qc", 32'(qc), 32'h1);
        tick(); chk("rel3_qa", 32'(qa), 32'h1); chk("rel3_qc", 32'(qc), 32'h0);

        // Reset mid-count with an override on bit 3
        load = 1'b1; load_val = 4'h7; mode = MH;
        tick(); chk("m7_qa", 32'(qa), 32'h7);
        load = 1'b0;
        ovr_set = 1'b1; ovr_mask = 4'b1000; ovr_data = 4'b1000;
        tick(); chk("mf_qa", 32'(qa), 32'hF);
        ovr_set = 1'b0; mode = MU; t = 4'b0001; reset = 1'b1;
        tick();
        chk("mrst_qa", 32'(qa), 32'h0); chk("mrst_tca", 32'(tca), 32'h0);
        chk("mrst_qc", 32'(qc), 32'h0);
        reset = 1'b0;

        // Load and override on the same edge, then hold and release
        mode = MH; load = 1'b1; load_val = 4'h5;
        ovr_set = 1'b1; ovr_mask = 4'b0011; ovr_data = 4'b0000;
        tick(); chk("lo1_qa", 32'(qa), 32'h4); chk("lo1_qc", 32'(qc), 32'h4);
        load = 1'b0; ovr_set = 1'b0;
        tick(); chk("lo2_qa", 32'(qa), 32'h4); chk("lo2_qc", 32'(qc), 32'h4);
        ovr_set = 1'b1; ovr_mask = 4'b0000;
        tick(); chk("lo3_qa", 32'(qa), 32'h4); chk("lo3_qc", 32'(qc), 32'h5);
        ovr_set = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
